// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: Bresenham accumulators produce one-cycle ce pulses at f_clk*NUM/DEN.
// ce/clk_q/lock are registered; a config request waits in a per-channel pending slot (cfg_ready low) until the next period boundary.
module frac_clken_gen #(
  parameter int CHANNELS    = 2,
  parameter int ACC_W       = 16,
  parameter int DEF_NUM     = 1,
  parameter int DEF_DEN     = 4,
  parameter int LOCK_PULSES = 4,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [ACC_W-1:0]    cfg_num,
  input  logic [ACC_W-1:0]    cfg_den,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] ce,
  output logic [CHANNELS-1:0] clk_q,
  output logic [CHANNELS-1:0] lock
);

  localparam int LK_W = $clog2(LOCK_PULSES + 1);
  localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_PULSES);

  logic [CHANNELS-1:0][ACC_W-1:0] acc_q, acc_d;
  logic [CHANNELS-1:0][ACC_W-1:0] num_q, num_d;
  logic [CHANNELS-1:0][ACC_W-1:0] den_q, den_d;
  logic [CHANNELS-1:0][ACC_W-1:0] pend_num_q, pend_num_d;
  logic [CHANNELS-1:0][ACC_W-1:0] pend_den_q, pend_den_d;
  logic [CHANNELS-1:0]            pend_vld_q, pend_vld_d;
  logic [CHANNELS-1:0][LK_W-1:0]  cnt_q, cnt_d;
  logic [CHANNELS-1:0]            ce_q, ce_d;
  logic [CHANNELS-1:0]            tgl_q, tgl_d;
  logic [CHANNELS-1:0]            lock_q, lock_d;
  logic                           cfg_err_q, cfg_err_d;

  logic [CHANNELS-1:0][ACC_W:0]   sum;
  logic [CHANNELS-1:0]            stopped;
  logic [CHANNELS-1:0]            wrap;
  logic [CHANNELS-1:0]            apply;
  logic                           cfg_ch_ok;
  logic                           cfg_sel_pend;
  logic                           xfer;
  logic                           req_ok;

  // Decode cfg_ch by comparison so an out-of-range channel never indexes the arrays.
  always_comb begin
    cfg_ch_ok    = 1'b0;
    cfg_sel_pend = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ch_ok    = 1'b1;
        cfg_sel_pend = pend_vld_q[i];
      end
    end
  end

  assign cfg_ready = !rst && !cfg_sel_pend;
  assign xfer      = cfg_valid && cfg_ready;
  assign req_ok    = cfg_ch_ok && (cfg_den != '0) && (cfg_num <= cfg_den);
  assign cfg_err_d = xfer && !req_ok;

  always_comb begin
    acc_d      = acc_q;
    num_d      = num_q;
    den_d      = den_q;
    pend_num_d = pend_num_q;
    pend_den_d = pend_den_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    ce_d       = '0;
    tgl_d      = tgl_q;
    lock_d     = '0;
    sum        = '0;
    stopped    = '0;
    wrap       = '0;
    apply      = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]     = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      stopped[i] = (num_q[i] == '0);
      wrap[i]    = !stopped[i] && (sum[i] >= {1'b0, den_q[i]});
      apply[i]   = pend_vld_q[i] && (wrap[i] || stopped[i]);

      ce_d[i]  = wrap[i];
      tgl_d[i] = tgl_q[i] ^ wrap[i];
      acc_d[i] = wrap[i] ? ACC_W'(sum[i] - {1'b0, den_q[i]}) : sum[i][ACC_W-1:0];

      if (stopped[i]) begin
        cnt_d[i] = '0;
      end else if (wrap[i] && (cnt_q[i] != LK_MAX)) begin
        cnt_d[i] = cnt_q[i] + LK_W'(1);
      end
      lock_d[i] = !stopped[i] && (cnt_d[i] == LK_MAX);

      // The wrap that triggers an apply keeps its ce; the new ratio starts from acc=0 next cycle.
      if (apply[i]) begin
        num_d[i]      = pend_num_q[i];
        den_d[i]      = pend_den_q[i];
        acc_d[i]      = '0;
        cnt_d[i]      = '0;
        lock_d[i]     = 1'b0;
        pend_vld_d[i] = 1'b0;
      end

      if (xfer && req_ok && (cfg_ch == CH_W'(i))) begin
        pend_vld_d[i] = 1'b1;
        pend_num_d[i] = cfg_num;
        pend_den_d[i] = cfg_den;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        acc_q[i]      <= '0;
        num_q[i]      <= ACC_W'(DEF_NUM);
        den_q[i]      <= ACC_W'(DEF_DEN);
        pend_num_q[i] <= '0;
        pend_den_q[i] <= '0;
        cnt_q[i]      <= '0;
      end
      pend_vld_q <= '0;
      ce_q       <= '0;
      tgl_q      <= '0;
      lock_q     <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      num_q      <= num_d;
      den_q      <= den_d;
      pend_num_q <= pend_num_d;
      pend_den_q <= pend_den_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      ce_q       <= ce_d;
      tgl_q      <= tgl_d;
      lock_q     <= lock_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign ce      = ce_q;
  assign clk_q   = tgl_q;
  assign lock    = lock_q;
  assign cfg_err = cfg_err_q;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen (2 channels, 16-bit, defaults 1/4, lock after 4 pulses).
module tb_frac_clken_gen;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_num;
  logic [15:0] cfg_den;
  logic        cfg_err;
  logic [1:0]  ce;
  logic [1:0]  clk_q;
  logic [1:0]  lock;

  int checks;
  int failures;
  int cyc;

  frac_clken_gen #(
    .CHANNELS(2), .ACC_W(16), .DEF_NUM(1), .DEF_DEN(4), .LOCK_PULSES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_num(cfg_num), .cfg_den(cfg_den), .cfg_err(cfg_err),
    .ce(ce), .clk_q(clk_q), .lock(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic request(input logic ch, input int num, input int den);
    cfg_ch    = ch;
    cfg_num   = 16'(num);
    cfg_den   = 16'(den);
    cfg_valid = 1'b1;
    #1;
  endtask

  // ch1 at 3/8 applied at cycle 44: pulses at offsets 2,5,7 of each 8-cycle period from cycle 45.
  function automatic logic exp_ce1(input int k);
    int m;
    m = (k - 45) % 8;
    return (m == 2) || (m == 5) || (m == 7);
  endfunction

  int ce1_count;
  int last_ce1;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_num = '0; cfg_den = '0;

    repeat (3) step();
    chk("rst_ce", ce, 0);
    chk("rst_clk_q", clk_q, 0);
    chk("rst_lock", lock, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 0);

    // Defaults: ce every 4th cycle, clk_q period 8, lock from cycle 16.
    rst = 1'b0; cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      chk("def_ce", ce, (k % 4 == 0) ? 2'b11 : 2'b00);
      chk("def_clk_q", clk_q, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
      chk("def_lock", lock, (k >= 16) ? 2'b11 : 2'b00);
    end

    // ch1 -> 3/8, requested right after its wrap at cycle 40; applies at wrap 44.
    request(1'b1, 3, 8);
    chk("t2_ready_pre", cfg_ready, 1);
    ce1_count = 0; last_ce1 = 44;
    for (int k = 41; k <= 108; k++) begin
      step();
      if (k == 41) cfg_valid = 1'b0;
      if (k <= 44) chk("t2_ready_ch1", cfg_ready, (k == 44) ? 1 : 0);
      chk("t2_ce0", ce[0], (k % 4 == 0) ? 1 : 0);
      chk("t2_lock0", lock[0], 1);
      chk("t2_ce1", ce[1], (k < 44) ? 0 : (k == 44) ? 1 : exp_ce1(k));
      chk("t2_lock1", lock[1], (k < 44) ? 1 : (k >= 55) ? 1 : 0);
      chk("t2_cfg_err", cfg_err, 0);
      if (k >= 45 && ce[1]) begin
        ce1_count++;
        chk("t2_gap", ((k - last_ce1) == 2 || (k - last_ce1) == 3) ? 1 : 0, 1);
        last_ce1 = k;
      end
    end
    chk("t2_count", ce1_count, 24);

    // ch0 1/4 -> 1/1 one cycle after wrap 108: held pending until wrap 112.
    request(1'b0, 1, 1);
    chk("t3_ready_pre", cfg_ready, 1);
    for (int k = 109; k <= 120; k++) begin
      step();
      if (k == 109) cfg_valid = 1'b0;
      if (k <= 113) chk("t3_ready_ch0", cfg_ready, (k >= 112) ? 1 : 0);
      chk("t3_ce0", ce[0], (k >= 112) ? 1 : 0);
      chk("t3_lock0", lock[0], (k < 112) ? 1 : (k >= 116) ? 1 : 0);
      if (k >= 112) chk("t3_clk_q0", clk_q[0], (k - 112) % 2);
      chk("t3_ce1", ce[1], exp_ce1(k));
    end

    // Invalid requests: num>den, then den==0.
    request(1'b0, 5, 3);
    chk("t4_ready0", cfg_ready, 1);
    step();
    chk("t4_err_a", cfg_err, 1);
    request(1'b1, 2, 0);
    chk("t4_ready1", cfg_ready, 1);
    step();
    chk("t4_err_b", cfg_err, 1);
    chk("t4_ce0_b", ce[0], 1);
    cfg_valid = 1'b0;
    step();
    chk("t4_err_c", cfg_err, 0);
    chk("t4_ce0_c", ce[0], 1);
    chk("t4_ce1_c", ce[1], exp_ce1(cyc));
    chk("t4_lock", lock, 2'b11);
    cfg_ch = 1'b0; #1;
    chk("t4_slot0_empty", cfg_ready, 1);
    cfg_ch = 1'b1; #1;
    chk("t4_slot1_empty", cfg_ready, 1);

    // Stop ch1 with 0/1: last ce at wrap 127, then silent.
    step();
    chk("t5_ce1_124", ce[1], 1);
    request(1'b1, 0, 1);
    chk("t5_ready_stop", cfg_ready, 1);
    for (int k = 125; k <= 132; k++) begin
      step();
      if (k == 125) cfg_valid = 1'b0;
      chk("t5_ce1_stop", ce[1], (k == 127) ? 1 : 0);
      chk("t5_lock1_stop", lock[1], (k < 127) ? 1 : 0);
      chk("t5_ce0", ce[0], 1);
    end

    // Restart ch1 at 1/2: accepted at 133, applied at 134, pulses on even cycles from 136.
    request(1'b1, 1, 2);
    chk("t5_ready_go", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    chk("t5_ready_133", cfg_ready, 0);
    chk("t5_ce1_133", ce[1], 0);
    step();
    chk("t5_ready_134", cfg_ready, 1);
    chk("t5_ce1_134", ce[1], 0);
    chk("t5_lock1_134", lock[1], 0);
    step();
    chk("t5_ce1_135", ce[1], 0);
    for (int k = 136; k <= 144; k++) begin
      step();
      chk("t5_ce1_run", ce[1], (k % 2 == 0) ? 1 : 0);
      chk("t5_lock1_run", lock[1], (k >= 142) ? 1 : 0);
    end

    // Reset for one cycle with a pending ch1 request; defaults must resume.
    request(1'b1, 1, 3);
    chk("t6_ready_pre", cfg_ready, 1);
    step();
    chk("t6_ce_145", ce, 2'b01);
    cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_ready_rst", cfg_ready, 0);
    step();
    chk("t6_ce", ce, 0);
    chk("t6_clk_q", clk_q, 0);
    chk("t6_lock", lock, 0);
    chk("t6_cfg_err", cfg_err, 0);
    rst = 1'b0; cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1) chk("t6_slot1_dropped", cfg_ready, 1);
      chk("t6_ce_def", ce, (k % 4 == 0) ? 2'b11 : 2'b00);
      chk("t6_clk_q_def", clk_q, ((k / 4) % 2 == 1) ? 2'b11 : 2'b00);
      chk("t6_lock_def", lock, (k >= 16) ? 2'b11 : 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
